// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the core that fetches from its RAM.
package prog_loader_pkg;

    localparam int         ADDR_W_DEF = 8;
    localparam int         INST_W_DEF = 13;
    localparam logic [7:0] MAGIC_DEF  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        LO,
        HI,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one asynchronous read port.
module prog_ram #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read during a write sees the old word until the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles instructions into prog_ram and
// releases the core from reset once a checksum-valid image is in place.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         INST_W = INST_W_DEF,
    parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] word_count
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        csum;
    logic [7:0]        sum_next;
    logic [7:0]        n_cnt;
    logic [7:0]        lo_byte;
    logic              accept;
    logic              is_magic;
    logic              hi_bad;
    logic              last_word;
    logic              we;
    logic [INST_W-1:0] wdata;

    // Bits of the high byte above the instruction width must be zero.
    function automatic logic reserved_bad(input logic [7:0] hi);
        return (hi >> (INST_W - 8)) != 8'd0;
    endfunction

    function automatic logic [INST_W-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        w = {hi, lo};
        return w[INST_W-1:0];
    endfunction

    assign accept    = rx_valid && rx_ready;
    assign is_magic  = (rx_data == MAGIC);
    assign sum_next  = csum + rx_data;
    assign hi_bad    = reserved_bad(rx_data);
    assign last_word = (32'(word_count) + 32'd1) == 32'(n_cnt);
    assign we        = accept && (state == HI) && !hi_bad;
    assign wdata     = pack_word(rx_data, lo_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (is_magic) state_nxt = COUNT;
                COUNT:   state_nxt = (rx_data == 8'd0) ? CSUM : LO;
                LO:      state_nxt = HI;
                HI: begin
                    if (hi_bad) begin
                        state_nxt = ERR;
                    end else if (last_word) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = LO;
                    end
                end
                CSUM:    state_nxt = (sum_next == 8'd0) ? DONE : ERR;
                DONE:    state_nxt = DONE;
                ERR:     if (is_magic) state_nxt = COUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decode the registered state, so they follow the deciding byte by one cycle.
    always_comb begin
        rx_ready  = (state != DONE);
        cpu_reset = (state != DONE);
        load_done = (state == DONE);
        load_err  = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum       <= 8'd0;
            word_count <= '0;
        end else if (accept) begin
            case (state)
                IDLE, ERR: if (is_magic) csum <= 8'd0;
                COUNT: begin
                    csum       <= sum_next;
                    word_count <= '0;
                end
                LO:        csum <= sum_next;
                HI: begin
                    if (!hi_bad) begin
                        csum       <= sum_next;
                        word_count <= word_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state == COUNT)) begin
            n_cnt <= rx_data;
        end
        if (accept && (state == LO)) begin
            lo_byte <= rx_data;
        end
    end

    prog_ram #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_count),
        .wdata (wdata),
        .raddr (pc),
        .rdata (inst)
    );

endmodule
